// File: rtl/attempt_controller.sv
// attempt_controller: sequences guesses through the key checker.
// Re-arms the checker (chk_rst) before every attempt, collects the
// pass/fail verdict, counts consecutive failures, enforces a timed
// lockout after MAX_FAILS failures and holds UNLOCKED until relock.
// All outputs are registered and change on the same edge as the state.
module attempt_controller #(
  parameter int unsigned ARM_CYCLES       = 16,
  parameter int unsigned FAIL_SHOW_CYCLES = 25_000_000,
  parameter int unsigned LOCKOUT_CYCLES   = 250_000_000,
  parameter int unsigned MAX_FAILS        = 3,
  parameter int unsigned ATTEMPT_TIMEOUT  = 0,
  parameter int unsigned CNT_W            = 32,
  parameter int unsigned FAIL_W           = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              relock,
  input  logic              chk_success,
  input  logic              chk_fail,
  output logic              chk_rst,
  output logic              unlocked,
  output logic              fail_led,
  output logic              locked_out,
  output logic [FAIL_W-1:0] fail_count,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    ARM       = 3'd0,
    ACTIVE    = 3'd1,
    FAIL_HOLD = 3'd2,
    LOCKOUT   = 3'd3,
    UNLOCKED  = 3'd4
  } state_e;

  // Terminal counter values: each timed state lasts exactly N cycles,
  // counting 0..N-1 from the cycle it is entered.
  localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(FAIL_SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   =
    CNT_W'((ATTEMPT_TIMEOUT == 0) ? 0 : ATTEMPT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAILS);
  localparam bit               TO_EN     = (ATTEMPT_TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [FAIL_W-1:0] nf;
  logic              timeout_hit;

  logic chk_rst_q, chk_rst_d;
  logic unlocked_q, unlocked_d;
  logic fail_led_q, fail_led_d;
  logic locked_out_q, locked_out_d;

  // Saturating failure increment: never exceeds MAX_FAILS.
  assign nf = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + FAIL_W'(1);

  // Timeout fires on the last allowed ACTIVE cycle; a verdict in the
  // same cycle is handled first by the next-state logic.
  assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);

  // State, counter, failure count and registered output flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARM;
      cnt_q        <= '0;
      fail_q       <= '0;
      chk_rst_q    <= 1'b1;
      unlocked_q   <= 1'b0;
      fail_led_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fail_q       <= fail_d;
      chk_rst_q    <= chk_rst_d;
      unlocked_q   <= unlocked_d;
      fail_led_q   <= fail_led_d;
      locked_out_q <= locked_out_d;
    end
  end

  // Next state and failure count; checker verdicts only matter in ACTIVE,
  // which discards sticky verdicts left over from a previous attempt.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    unique case (state_q)
      ARM: begin
        if (cnt_q >= ARM_LAST) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (chk_success) begin
          state_d = UNLOCKED;
          fail_d  = '0;
        end else if (chk_fail || timeout_hit) begin
          fail_d  = nf;
          state_d = (nf == FAIL_MAX) ? LOCKOUT : FAIL_HOLD;
        end
      end
      FAIL_HOLD: begin
        if (cnt_q >= SHOW_LAST) state_d = ARM;
      end
      LOCKOUT: begin
        if (cnt_q >= LOCK_LAST) begin
          state_d = ARM;
          fail_d  = '0;
        end
      end
      UNLOCKED: begin
        if (relock) state_d = ARM;
      end
      default: begin
        state_d = ARM;
      end
    endcase
  end

  // Cycle counter: clears on every state entry, otherwise counts up and
  // parks at all-ones rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output flags decoded from the next state so they register together
  // with it; the checker is held in reset everywhere except ACTIVE.
  always_comb begin
    chk_rst_d    = 1'b1;
    unlocked_d   = 1'b0;
    fail_led_d   = 1'b0;
    locked_out_d = 1'b0;
    unique case (state_d)
      ACTIVE:    chk_rst_d    = 1'b0;
      FAIL_HOLD: fail_led_d   = 1'b1;
      LOCKOUT:   locked_out_d = 1'b1;
      UNLOCKED:  unlocked_d   = 1'b1;
      default:   chk_rst_d    = 1'b1;
    endcase
  end

  assign chk_rst    = chk_rst_q;
  assign unlocked   = unlocked_q;
  assign fail_led   = fail_led_q;
  assign locked_out = locked_out_q;
  assign fail_count = fail_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_attempt_controller.sv
// tb_attempt_controller: phase-table stimulus with a scoreboard queue for
// the attempt controller (ARM=4, FAIL_SHOW=8, LOCKOUT=20, MAX=3, TO=50).
module tb_attempt_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       relock = 1'b0;
  logic       chk_success = 1'b0;
  logic       chk_fail = 1'b0;
  logic       chk_rst, unlocked, fail_led, locked_out;
  logic [3:0] fail_count;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_bad = 0;

  // One phase: inputs held for n cycles, expected state/fail_count after
  // every clock edge of the phase.
  typedef struct {
    logic       rl;
    logic       s;
    logic       f;
    int         n;
    logic [2:0] st;
    logic [3:0] fc;
  } phase_t;

  phase_t      tbl[$];
  logic [10:0] exp_q[$];

  wire [10:0] act = {chk_rst, unlocked, fail_led, locked_out, fail_count, state_dbg};

  always #5 clk = ~clk;

  attempt_controller #(
    .ARM_CYCLES(4), .FAIL_SHOW_CYCLES(8), .LOCKOUT_CYCLES(20),
    .MAX_FAILS(3), .ATTEMPT_TIMEOUT(50), .CNT_W(32), .FAIL_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .relock(relock),
    .chk_success(chk_success), .chk_fail(chk_fail),
    .chk_rst(chk_rst), .unlocked(unlocked), .fail_led(fail_led),
    .locked_out(locked_out), .fail_count(fail_count), .state_dbg(state_dbg)
  );

  // Expected outputs from the state encoding: checker reset everywhere
  // except ACTIVE(1); one flag each for UNLOCKED(4), FAIL_HOLD(2), LOCKOUT(3).
  function automatic logic [10:0] exp_out(input logic [2:0] st, input logic [3:0] fc);
    return {st != 3'd1, st == 3'd4, st == 3'd2, st == 3'd3, fc, st};
  endfunction

  task automatic compare(input string nm, input logic [10:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {crst,unl,fled,lock,fc,st}=%b_%b_%b_%b_%0d_%0d required %b_%b_%b_%b_%0d_%0d",
               nm, $time, act[10], act[9], act[8], act[7], act[6:3], act[2:0],
               exp[10], exp[9], exp[8], exp[7], exp[6:3], exp[2:0]);
    end
  endtask

  task automatic add(input logic rl, input logic s, input logic f, input int n,
                     input logic [2:0] st, input logic [3:0] fc);
    phase_t p;
    p.rl = rl; p.s = s; p.f = f; p.n = n; p.st = st; p.fc = fc;
    tbl.push_back(p);
  endtask

  // Apply the table: drive each cycle, push its expectation, pop and
  // compare once the DUT has registered the edge.
  task automatic run_tbl(input string nm);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        relock      = tbl[i].rl;
        chk_success = tbl[i].s;
        chk_fail    = tbl[i].f;
        exp_q.push_back(exp_out(tbl[i].st, tbl[i].fc));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s: scoreboard empty, got %b required an entry", nm, act);
        end else begin
          compare($sformatf("%s[%0d.%0d]", nm, i, k), exp_q.pop_front());
        end
      end
    end
    relock = 1'b0; chk_success = 1'b0; chk_fail = 1'b0;
    tbl.delete();
  endtask

  // FAIL_HOLD after its entry edge, then ARM, then ACTIVE again.
  task automatic add_hold_rearm(input logic f, input logic [3:0] fc);
    add(0, 0, f, 7, 3'd2, fc);
    add(0, 0, f, 1, 3'd0, fc);
    add(0, 0, f, 3, 3'd0, fc);
    add(0, 0, 0, 1, 3'd1, fc);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    compare("reset", exp_out(3'd0, 4'd0));
    #2 rst_n = 1'b1;

    // 1: arm 4 cycles, success in ACTIVE -> UNLOCKED
    add(0, 0, 0, 3, 3'd0, 4'd0);
    add(0, 0, 0, 1, 3'd1, 4'd0);
    add(0, 0, 0, 3, 3'd1, 4'd0);
    add(0, 1, 0, 1, 3'd4, 4'd0);
    add(0, 0, 0, 3, 3'd4, 4'd0);
    // 6: relock -> ARM next cycle, ACTIVE 4 cycles later
    add(1, 0, 0, 1, 3'd0, 4'd0);
    add(0, 0, 0, 3, 3'd0, 4'd0);
    add(0, 0, 0, 1, 3'd1, 4'd0);
    run_tbl("unlock_relock");

    // 2/4: first fail with sticky chk_fail held through FAIL_HOLD and ARM
    add(0, 0, 1, 1, 3'd2, 4'd1);
    add_hold_rearm(1'b1, 4'd1);
    add(0, 0, 0, 2, 3'd1, 4'd1);
    // second fail
    add(0, 0, 1, 1, 3'd2, 4'd2);
    add_hold_rearm(1'b0, 4'd2);
    // 3: third fail -> LOCKOUT 20 cycles; relock ignored in LOCKOUT
    add(0, 0, 1, 1, 3'd3, 4'd3);
    add(1, 0, 0, 1, 3'd3, 4'd3);
    add(0, 0, 0, 18, 3'd3, 4'd3);
    add(0, 0, 0, 1, 3'd0, 4'd0);
    add(0, 0, 0, 3, 3'd0, 4'd0);
    add(0, 0, 0, 1, 3'd1, 4'd0);
    run_tbl("fails_lockout");

    // 4: one fail, then success and fail together -> success wins
    add(0, 0, 1, 1, 3'd2, 4'd1);
    add_hold_rearm(1'b0, 4'd1);
    add(0, 1, 1, 1, 3'd4, 4'd0);
    add(1, 0, 0, 1, 3'd0, 4'd0);
    add(0, 0, 0, 3, 3'd0, 4'd0);
    add(0, 0, 0, 1, 3'd1, 4'd0);
    // 5: no verdict for 50 ACTIVE cycles -> timeout failure
    add(0, 0, 0, 49, 3'd1, 4'd0);
    add(0, 0, 0, 1, 3'd2, 4'd1);
    add_hold_rearm(1'b0, 4'd1);
    // drive into LOCKOUT again for the reset corner
    add(0, 0, 1, 1, 3'd2, 4'd2);
    add_hold_rearm(1'b0, 4'd2);
    add(0, 0, 1, 1, 3'd3, 4'd3);
    add(0, 0, 0, 5, 3'd3, 4'd3);
    run_tbl("both_timeout");

    // 6: asynchronous reset mid-LOCKOUT takes effect without a clock edge
    #2 rst_n = 1'b0;
    #1;
    compare("rst_mid_lockout", exp_out(3'd0, 4'd0));
    #2 rst_n = 1'b1;
    add(0, 0, 0, 3, 3'd0, 4'd0);
    add(0, 0, 0, 1, 3'd1, 4'd0);
    run_tbl("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/attempt_controller.md
Name: attempt_controller

Overview:
- Sequences repeated guesses through the key-checker datapath: re-arms it, collects each pass/fail verdict, and counts consecutive failures.
- Enforces a lockout after too many failures and holds the unlocked state until the user relocks.
- Sits between the top level (LEDs, relock button) and the key checker, and drives the checker's synchronous reset.

Parameters:
- ARM_CYCLES, 16, cycles chk_rst is held high before each attempt opens (min 1).
- FAIL_SHOW_CYCLES, 25_000_000, cycles fail_led is held after a non-terminal failure (min 1).
- LOCKOUT_CYCLES, 250_000_000, cycles spent in lockout (min 1).
- MAX_FAILS, 3, consecutive failures that trigger lockout (min 1).
- ATTEMPT_TIMEOUT, 0, cycles allowed in ACTIVE before the attempt counts as failed; 0 disables the timeout.
- CNT_W, 32, width of the shared cycle counter; must hold the largest cycle parameter.
- FAIL_W, 4, width of fail_count; must hold MAX_FAILS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- relock  in  1  single-cycle synchronous pulse from a debounced button
- chk_success  in  1  checker verdict: key matched (sticky until chk_rst)
- chk_fail  in  1  checker verdict: key mismatched (sticky until chk_rst)
- chk_rst  out  1  synchronous active-high reset to the key checker
- unlocked  out  1  high while in UNLOCKED
- fail_led  out  1  high while in FAIL_HOLD
- locked_out  out  1  high while in LOCKOUT
- fail_count  out  FAIL_W  current consecutive-failure count
- state_dbg  out  3  encoded state: ARM=0, ACTIVE=1, FAIL_HOLD=2, LOCKOUT=3, UNLOCKED=4

Behaviour:
- All outputs are registered. The cycle counter clears on every state entry.
- Reset (rst_n low, asynchronous):
  - state = ARM, counter = 0, fail_count = 0.
  - chk_rst = 1; unlocked, fail_led, locked_out = 0.
- chk_rst = 1 in every state except ACTIVE. It is 0 exactly while state_dbg = 1.
- chk_success and chk_fail are ignored outside ACTIVE. This discards stale sticky verdicts.
- ARM:
  - Counts ARM_CYCLES cycles, then enters ACTIVE.
  - chk_rst is therefore high for exactly ARM_CYCLES cycles after reset, or after any re-entry.
- ACTIVE:
  - chk_success = 1: next state UNLOCKED; fail_count cleared to 0.
  - chk_fail = 1 (and chk_success = 0): nf = fail_count + 1, saturating at MAX_FAILS; fail_count <= nf. If nf == MAX_FAILS, go to LOCKOUT, else go to FAIL_HOLD.
  - Both high in the same cycle: success wins.
  - ATTEMPT_TIMEOUT > 0 and the counter reaches ATTEMPT_TIMEOUT - 1 with no verdict: handled exactly as chk_fail.
  - A verdict in that same cycle takes precedence over the timeout.
- FAIL_HOLD: fail_led = 1 for FAIL_SHOW_CYCLES cycles, then ARM.
- LOCKOUT:
  - locked_out = 1 for LOCKOUT_CYCLES cycles.
  - On exit, fail_count <= 0 and next state is ARM.
- UNLOCKED:
  - unlocked = 1 indefinitely.
  - A relock pulse moves to ARM; fail_count stays 0.
  - relock is ignored in all other states.
- Transitions take effect on the clock edge after the triggering condition. Output flags change on the same edge as state.
- Any reset mid-operation returns to the reset condition immediately. An in-progress count, lockout or unlock is lost.
- fail_count never exceeds MAX_FAILS. Counters do not wrap; each counter stops at its terminal value and exits.

Test Plan:
Bench parameters: ARM_CYCLES=4, FAIL_SHOW_CYCLES=8, LOCKOUT_CYCLES=20, MAX_FAILS=3, ATTEMPT_TIMEOUT=50.
1. Release rst_n, pulse chk_success 3 cycles into ACTIVE -> chk_rst high 4 cycles then low; unlocked=1 the cycle after the pulse; chk_rst=1; fail_count=0.
2. Two fails, each after entering ACTIVE -> fail_led high 8 cycles each time; fail_count goes 1 then 2; ARM holds 4 cycles before each re-entry to ACTIVE.
3. Third consecutive fail -> locked_out=1 for 20 cycles, fail_count=3 during lockout; then 0, ARM, ACTIVE after 4 more cycles.
4. chk_success and chk_fail high in the same ACTIVE cycle -> UNLOCKED; fail_count=0. Sticky chk_fail held high during FAIL_HOLD/ARM -> no extra count.
5. No verdict for 50 ACTIVE cycles -> FAIL_HOLD entered; fail_count incremented by 1.
6. In UNLOCKED, pulse relock -> state_dbg=0 next cycle, ACTIVE 4 cycles later. relock pulsed during LOCKOUT -> no effect. rst_n dropped mid-LOCKOUT -> immediate ARM, locked_out=0, fail_count=0.
